// File: rtl/scroll_pkg.sv
// scroll_pkg: shared FSM encodings, character constants and ring-index helper for scroll_sequencer
package scroll_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_SCROLL  = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;
  localparam int CHAR_BLANK = 0;
  localparam int MIN_LEN    = 4;
  // base < 2*len always holds, so one conditional subtract replaces a modulo
  function automatic logic [4:0] wrap_idx(input logic [4:0] base, input logic [4:0] len);
    return base >= len ? base - len : base;
  endfunction
endpackage

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: enabled prescaler producing a one-cycle tick every CLK_FREQ>>speed cycles
module scroll_tick_gen #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick
);
  localparam int CW = $clog2(CLK_FREQ);
  logic [CW-1:0] cnt, lim;
  // compare with >= so a speed change below the current count fires at once
  always_comb begin
    lim  = CW'((CLK_FREQ >> speed) - 1);
    tick = en && cnt >= lim;
  end
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: loads a short character message and rotates it across four seven-segment digits
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int MSG_LEN  = 8,
  parameter int CHAR_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load_valid,
  input  logic [CHAR_W-1:0]   load_char,
  input  logic                load_last,
  output logic                load_ready,
  input  logic                run,
  input  logic                dir,
  input  logic [1:0]          speed,
  output logic [4*CHAR_W-1:0] disp,
  output logic [3:0]          pos,
  output logic                step,
  output logic [1:0]          state
);
  localparam int IW = $clog2(MSG_LEN);
  logic [CHAR_W-1:0] mem [MSG_LEN];
  logic [4:0] count, count_n, len;
  logic [1:0] nxt;
  logic accept, msg_end, tick, loading;
  always_comb begin
    loading = state == ST_IDLE || state == ST_LOADING;
    accept  = load_valid && loading;
    count_n = count + 5'd1;
    msg_end = accept && (load_last || count_n == 5'(MSG_LEN));
  end
  scroll_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear || msg_end),
    .en   (state == ST_SCROLL && run),
    .speed(speed),
    .tick (tick)
  );
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  always_comb
    nxt = clear ? ST_IDLE :
          msg_end ? (run ? ST_SCROLL : ST_HOLD) :
          accept ? ST_LOADING :
          (state == ST_SCROLL && !run) ? ST_HOLD :
          (state == ST_HOLD && run) ? ST_SCROLL : state;
  always_ff @(posedge clk)
    if (rst || clear) begin
      count <= '0;
      len   <= '0;
      pos   <= '0;
      step  <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= CHAR_W'(CHAR_BLANK);
    end else begin
      step <= tick;
      if (accept) begin
        mem[IW'(count)] <= load_char;
        count <= count_n;
      end
      if (msg_end) begin
        len <= count_n < 5'(MIN_LEN) ? 5'(MIN_LEN) : count_n;
        pos <= '0;
      end else if (tick)
        pos <= dir ? (pos == 4'd0 ? 4'(len - 5'd1) : pos - 4'd1)
                   : ({1'b0, pos} == len - 5'd1 ? 4'd0 : pos + 4'd1);
    end
  // while loading, show the raw first four entries so partial text is visible
  always_comb begin
    load_ready = loading;
    disp = '0;
    for (int k = 0; k < 4; k++)
      disp[k*CHAR_W +: CHAR_W] = loading ? mem[IW'(k)]
                                         : mem[IW'(wrap_idx({1'b0, pos} + 5'(3 - k), len))];
  end
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: scoreboard bench; expected steps are queued by stimulus and checked by a step monitor
module tb_scroll_sequencer;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic load_valid = 1'b0, load_last = 1'b0, run = 1'b1, dir = 1'b0;
  logic [2:0] load_char = '0;
  logic [1:0] speed = '0;
  logic load_ready, step;
  logic [11:0] disp;
  logic [3:0] pos;
  logic [1:0] state;
  int cyc = 0, vectors = 0, miscompares = 0, t0;

  typedef struct {int at; logic [3:0] pos; logic [11:0] disp;} exp_t;
  exp_t sb[$];

  scroll_sequencer #(.CLK_FREQ(8), .MSG_LEN(8), .CHAR_W(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load_valid(load_valid), .load_char(load_char),
    .load_last(load_last), .load_ready(load_ready), .run(run), .dir(dir), .speed(speed),
    .disp(disp), .pos(pos), .step(step), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] d4(input logic [2:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic push(input int at, input logic [3:0] p, input logic [11:0] d);
    exp_t e;
    e.at = at; e.pos = p; e.disp = d;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick1;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [2:0] c, input logic l);
    load_valid = 1'b1; load_char = c; load_last = l;
    tick1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic do_clear;
    tick1;
    clear = 1'b1;
    tick1;
    clear = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d got=%0d exp=0", sb.size(), sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk)
    if (!rst && step) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_step got pos=%0d disp=%h exp no step", pos, disp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pos !== e.pos || disp !== e.disp || (e.at >= 0 && cyc != e.at)) begin
          miscompares++;
          $display("FAIL step got pos=%0d disp=%h cyc=%0d exp pos=%0d disp=%h cyc=%0d",
                   pos, disp, cyc, e.pos, e.disp, e.at);
        end
      end
    end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_disp", disp, 0);
    chk("reset_ready", load_ready, 1);
    chk("reset_pos", pos, 0);
    // basic left scroll
    tick1;
    load(1, 0); load(2, 0); load(3, 0); load(4, 1);
    t0 = cyc;
    push(t0 + 8, 1, d4(2, 3, 4, 1));
    push(t0 + 16, 2, d4(3, 4, 1, 2));
    push(t0 + 24, 3, d4(4, 1, 2, 3));
    push(t0 + 32, 0, d4(1, 2, 3, 4));
    @(negedge clk);
    chk("left_state", state, 2);
    chk("left_disp", disp, d4(1, 2, 3, 4));
    drain(60);
    do_clear;
    @(negedge clk);
    chk("clear_state", state, 0);
    chk("clear_disp", disp, 0);
    chk("clear_ready", load_ready, 1);
    // right scroll
    tick1;
    dir = 1'b1;
    load(1, 0); load(2, 0); load(3, 0); load(4, 1);
    t0 = cyc;
    push(t0 + 8, 3, d4(4, 1, 2, 3));
    push(t0 + 16, 2, d4(3, 4, 1, 2));
    drain(40);
    do_clear;
    // short message padded to four
    tick1;
    dir = 1'b0;
    load(5, 0); load(6, 1);
    push(-1, 1, d4(6, 0, 0, 5));
    push(-1, 2, d4(0, 0, 5, 6));
    @(negedge clk);
    chk("short_disp", disp, d4(5, 6, 0, 0));
    drain(40);
    do_clear;
    // full buffer ends the message without last
    tick1;
    load(1, 0); load(2, 0); load(3, 0); load(4, 0);
    load(5, 0); load(6, 0); load(7, 0); load(1, 0);
    t0 = cyc;
    push(t0 + 8, 1, d4(2, 3, 4, 5));
    push(t0 + 16, 2, d4(3, 4, 5, 6));
    push(t0 + 24, 3, d4(4, 5, 6, 7));
    push(t0 + 32, 4, d4(5, 6, 7, 1));
    push(t0 + 40, 5, d4(6, 7, 1, 1));
    push(t0 + 48, 6, d4(7, 1, 1, 2));
    push(t0 + 56, 7, d4(1, 1, 2, 3));
    push(t0 + 64, 0, d4(1, 2, 3, 4));
    @(negedge clk);
    chk("full_ready", load_ready, 0);
    chk("full_state", state, 2);
    chk("full_disp", disp, d4(1, 2, 3, 4));
    drain(100);
    do_clear;
    // hold mid-period, resume, then fastest speed
    tick1;
    load(1, 0); load(2, 0); load(3, 0); load(4, 1);
    repeat (2) @(posedge clk);
    #1 run = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("hold_state", state, 3);
    chk("hold_pos", pos, 0);
    chk("hold_step", step, 0);
    tick1;
    run = 1'b1;
    push(cyc + 7, 1, d4(2, 3, 4, 1));
    drain(20);
    tick1;
    speed = 2'd3;
    t0 = cyc;
    push(t0 + 1, 2, d4(3, 4, 1, 2));
    push(t0 + 2, 3, d4(4, 1, 2, 3));
    push(t0 + 3, 0, d4(1, 2, 3, 4));
    push(t0 + 4, 1, d4(2, 3, 4, 1));
    repeat (4) @(posedge clk);
    #1 run = 1'b0;
    speed = 2'd0;
    @(posedge clk);
    @(negedge clk);
    chk("fast_hold_state", state, 3);
    chk("fast_hold_pos", pos, 1);
    tick1;
    load_valid = 1'b1; load_char = 3'd7; load_last = 1'b1;
    repeat (3) @(posedge clk);
    #1 load_valid = 1'b0; load_last = 1'b0;
    @(negedge clk);
    chk("hold_ignore_disp", disp, d4(2, 3, 4, 1));
    chk("hold_ignore_ready", load_ready, 0);
    drain(10);
    do_clear;
    // clear with a simultaneous load during scroll
    tick1;
    run = 1'b1;
    load(1, 0); load(2, 0); load(3, 0); load(4, 1);
    clear = 1'b1; load_valid = 1'b1; load_char = 3'd5;
    tick1;
    clear = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    chk("clr_scroll_state", state, 0);
    chk("clr_scroll_disp", disp, 0);
    tick1;
    load(6, 1);
    @(negedge clk);
    chk("clr_count_disp", disp, d4(6, 0, 0, 0));
    do_clear;
    // reset mid-loading
    tick1;
    load(1, 0); load(2, 0);
    @(negedge clk);
    chk("loading_state", state, 1);
    chk("loading_disp", disp, d4(0, 0, 2, 1));
    tick1;
    rst = 1'b1;
    tick1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_disp", disp, 0);
    chk("rst_ready", load_ready, 1);
    tick1;
    run = 1'b0;
    load(3, 1);
    @(negedge clk);
    chk("end_hold_state", state, 3);
    chk("end_hold_disp", disp, d4(3, 0, 0, 0));
    repeat (20) @(posedge clk);
    drain(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/scroll_sequencer.md
# scroll_sequencer

Controller that sequences a short message of character codes across the four-digit seven-segment display datapath. The host loads up to MSG_LEN characters through a valid/ready port. The block then rotates the message across HEX3..HEX0 at a selectable step rate, with pause and direction control. It drives per-digit character codes into the existing mux/decoder path and replaces the fixed 2-bit rotating counter.

## Interface
- CLK_FREQ, 50000000: clock cycles per 1 s step at speed 0; minimum 8.
- MSG_LEN, 8: message buffer depth, 4..16.
- CHAR_W, 3: character code width; code 0 is blank.
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- clear  in  1  sync flush to IDLE; takes priority over every input except rst.
- load_valid  in  1  character offered.
- load_char  in  CHAR_W  offered character code.
- load_last  in  1  marks the offered character as the final one; sampled only on accept.
- load_ready  out  1  block accepts characters.
- run  in  1  1 = scroll, 0 = hold.
- dir  in  1  0 = scroll left (pos+1), 1 = scroll right (pos-1).
- speed  in  2  step period = CLK_FREQ >> speed cycles.
- disp  out  4*CHAR_W  digit codes; MSB field = HEX3.
- pos  out  4  current head index.
- step  out  1  one-cycle pulse on each pos change.
- state  out  2  current FSM state.

## Operation
- FSM states: IDLE=0, LOADING=1, SCROLL=2, HOLD=3.
- Reset or clear:
  - state=IDLE, count=0, len=0, pos=0, step=0.
  - All buffer entries are set to blank; the prescaler is set to 0.
  - disp=0 and load_ready=1.
- load_ready=1 only in IDLE and LOADING.
- An accept is load_valid & load_ready. It writes buf[count] and increments count. IDLE goes to LOADING on the first accept.
- Message end occurs on an accept with load_last=1, or on the accept that makes count=MSG_LEN:
  - len = max(count,4); unwritten entries below len stay blank.
  - pos=0 and the prescaler is set to 0.
  - Next state is SCROLL if run=1 in that cycle, otherwise HOLD.
- SCROLL:
  - The prescaler increments each cycle.
  - When prescaler >= (CLK_FREQ>>speed)-1: prescaler goes to 0, step=1, and pos advances.
  - dir=0: pos+1, with len-1 wrapping to 0.
  - dir=1: pos-1, with 0 wrapping to len-1.
- Run control:
  - run=0 in SCROLL moves to HOLD. The prescaler is frozen and no step occurs.
  - run=1 in HOLD returns to SCROLL. The prescaler resumes from its frozen value.
- load_valid is ignored in SCROLL and HOLD. Reloading requires clear.
- disp field k (k=3 for HEX3 down to 0) = buf[(pos+3-k) mod len].
  - Because len>=4, the index needs one conditional subtract of len; no divider.
- In IDLE and LOADING, disp shows buf[3], buf[2], buf[1], buf[0] in fields 3..0, so partially loaded text is visible.

## Timing
- All state, pos, step, buf and prescaler values are registered.
- disp and pos change in the same cycle, one clock after the terminal-count cycle.
- The step pulse and the pos change are in the same cycle.
- First step comes CLK_FREQ>>speed cycles after entering SCROLL.
- A speed change takes effect immediately. If the prescaler is already at or beyond the new limit, the step fires on the next clock.
- The cycle after clear or rst: load_ready=1 and disp=0. A load_valid in the same cycle as clear is discarded.
- load_ready falls one cycle after the message-end accept. There are no back-to-back accepts beyond MSG_LEN.
- A dir change takes effect at the next step; pos is not recomputed.

## Structure
- Package scroll_pkg:
  - State localparams: ST_IDLE, ST_LOADING, ST_SCROLL, ST_HOLD.
  - CHAR_BLANK=0 and MIN_LEN=4.
- Sub-module scroll_tick_gen:
  - Parameterised prescaler with enable (run), sync clear, and period = CLK_FREQ>>speed.
  - Output: a one-cycle tick.
- Top level holds the FSM, buffer, pos arithmetic and the disp index logic.

## Test plan
- **Basic left scroll.** CLK_FREQ=8, speed=0, run=1, dir=0; load 1,2,3,4 with last on 4.
  - disp={1,2,3,4} with state=SCROLL.
  - 8 cycles later: step=1 with disp={2,3,4,1}.
  - Four steps return pos to 0.
- **Right scroll.** Same message, dir=1.
  - First step: pos=3, disp={4,1,2,3}.
- **Short message.** Load 5,6 with last.
  - len=4 and disp={5,6,0,0}.
  - Steps give {6,0,0,5}, then {0,0,5,6}.
- **Full buffer.** MSG_LEN=8; load 1..7,1 with no last.
  - load_ready=0 after the 8th accept, state=SCROLL, len=8.
  - After 4 steps: disp={5,6,7,1}.
- **Hold and speed.** Set run=0 for 100 cycles mid-period.
  - pos is unchanged and step=0.
  - After resume, the step comes at the remaining prescaler count.
  - With speed=3, a step occurs every cycle.
- **Clear, reset and ignored loads.**
  - clear together with load_valid during SCROLL: next cycle state=IDLE, disp=0, count=0.
  - rst mid-LOADING gives the same result.
  - load_valid in HOLD does not change buf.
